dcache_mem_ctrl: RTL and testbench

DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

---
 rtl/dcache_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller for the dcache: a write queue for writebacks and write
// misses, plus MSHRs that merge read misses into single block loads and fills.
module dcache_mem_ctrl #(
  parameter int LSQSZ    = 8,
  parameter int WQ_DEPTH = 4,
  parameter int MSHR_NUM = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_en_in,
  input  logic [15:0]      wb_addr_in,
  input  logic [63:0]      wb_data_in,
  input  logic [1:0]       wb_size_in,
  input  logic             wr_en_in,
  input  logic [15:0]      wr_addr_in,
  input  logic [63:0]      wr_data_in,
  input  logic [1:0]       wr_size_in,
  input  logic             rd_en_in,
  input  logic [15:0]      rd_addr_in,
  input  logic [1:0]       rd_size_in,
  input  logic [LSQSZ-1:0] rd_gnt_in,
  output logic             req_stall,
  output logic [1:0]       proc2mem_command,
  output logic [15:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [1:0]       proc2mem_size,
  input  logic [3:0]       mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [3:0]       mem2proc_tag,
  output logic             fill_en,
  output logic [4:0]       fill_idx,
  output logic [7:0]       fill_tag,
  output logic [63:0]      fill_data,
  output logic [LSQSZ-1:0] fill_gnt
);
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_LOAD = 2'd1, CMD_STORE = 2'd2;
  localparam logic [1:0] ST_FREE = 2'd0, ST_WAIT_ISSUE = 2'd1, ST_WAIT_DATA = 2'd2;
  localparam int WQ_PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int WQ_CW = $clog2(WQ_DEPTH + 1);
  localparam int MI_W  = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
  localparam int MC_W  = $clog2(MSHR_NUM + 1);

  logic [15:0]      wq_addr_q [WQ_DEPTH], wq_addr_d [WQ_DEPTH];
  logic [63:0]      wq_data_q [WQ_DEPTH], wq_data_d [WQ_DEPTH];
  logic [1:0]       wq_size_q [WQ_DEPTH], wq_size_d [WQ_DEPTH];
  logic [WQ_PW-1:0] wq_head_q, wq_head_d, wq_tail_q, wq_tail_d;
  logic [WQ_CW-1:0] wq_cnt_q, wq_cnt_d;

  logic [1:0]       ms_st_q [MSHR_NUM], ms_st_d [MSHR_NUM];
  logic [12:0]      ms_blk_q [MSHR_NUM], ms_blk_d [MSHR_NUM];
  logic [LSQSZ-1:0] ms_mask_q [MSHR_NUM], ms_mask_d [MSHR_NUM];
  logic [3:0]       ms_tag_q [MSHR_NUM], ms_tag_d [MSHR_NUM];

  // Issue-order queue of MSHR indices: its head is always the oldest WAIT_ISSUE entry.
  logic [MI_W-1:0]  iq_q [MSHR_NUM], iq_d [MSHR_NUM];
  logic [MI_W-1:0]  iq_head_q, iq_head_d, iq_tail_q, iq_tail_d;
  logic [MC_W-1:0]  iq_cnt_q, iq_cnt_d;
  logic             iq_push;

  logic             fill_en_q, fill_en_d;
  logic [4:0]       fill_idx_q, fill_idx_d;
  logic [7:0]       fill_tag_q, fill_tag_d;
  logic [63:0]      fill_data_q, fill_data_d;
  logic [LSQSZ-1:0] fill_gnt_q, fill_gnt_d;

  logic [MSHR_NUM-1:0] hit_vec, ret_vec, free_vec;
  logic                hit_any, ret_any, free_any;
  logic [MI_W-1:0]     hit_idx, ret_idx, free_idx, load_idx;
  logic                st_acc, ld_acc;
  logic                unused_rd_bits;

  assign unused_rd_bits = ^{rd_size_in, rd_addr_in[2:0]};

  function automatic logic [WQ_PW-1:0] wq_inc(input logic [WQ_PW-1:0] p);
    return (p == WQ_PW'(WQ_DEPTH - 1)) ? '0 : p + WQ_PW'(1);
  endfunction

  function automatic logic [MI_W-1:0] iq_inc(input logic [MI_W-1:0] p);
    return (p == MI_W'(MSHR_NUM - 1)) ? '0 : p + MI_W'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < MSHR_NUM; gi++) begin : g_mshr
      assign hit_vec[gi]  = (ms_st_q[gi] != ST_FREE) && (ms_blk_q[gi] == rd_addr_in[15:3]);
      assign ret_vec[gi]  = (mem2proc_tag != 4'd0) && (ms_st_q[gi] == ST_WAIT_DATA) &&
                            (ms_tag_q[gi] == mem2proc_tag);
      assign free_vec[gi] = (ms_st_q[gi] == ST_FREE);
    end
  endgenerate

  always_comb begin
    hit_any = 1'b0; ret_any = 1'b0; free_any = 1'b0;
    hit_idx = '0;   ret_idx = '0;   free_idx = '0;
    for (int i = MSHR_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i])  begin hit_any  = 1'b1; hit_idx  = MI_W'(i); end
      if (ret_vec[i])  begin ret_any  = 1'b1; ret_idx  = MI_W'(i); end
      if (free_vec[i]) begin free_any = 1'b1; free_idx = MI_W'(i); end
    end
  end

  // Output process: command comes purely from registered state.
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    load_idx         = iq_q[iq_head_q];
    if (wq_cnt_q != '0) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = wq_addr_q[wq_head_q];
      proc2mem_data    = wq_data_q[wq_head_q];
      proc2mem_size    = wq_size_q[wq_head_q];
    end else if (iq_cnt_q != '0) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = {ms_blk_q[load_idx], 3'b000};
      proc2mem_size    = 2'd3;
    end
  end

  assign req_stall = (wq_cnt_q >= WQ_CW'(WQ_DEPTH - 1)) || !free_any;
  assign st_acc    = (proc2mem_command == CMD_STORE) && (mem2proc_response != 4'd0);
  assign ld_acc    = (proc2mem_command == CMD_LOAD) && (mem2proc_response != 4'd0);

  always_comb begin
    wq_addr_d = wq_addr_q; wq_data_d = wq_data_q; wq_size_d = wq_size_q;
    wq_head_d = wq_head_q; wq_tail_d = wq_tail_q; wq_cnt_d  = wq_cnt_q;
    ms_st_d   = ms_st_q;   ms_blk_d  = ms_blk_q;  ms_mask_d = ms_mask_q; ms_tag_d = ms_tag_q;
    iq_d      = iq_q;      iq_head_d = iq_head_q; iq_tail_d = iq_tail_q;
    iq_push   = 1'b0;
    fill_en_d = 1'b0; fill_idx_d = '0; fill_tag_d = '0; fill_data_d = '0; fill_gnt_d = '0;

    // Room is judged before this cycle's pop, so a full queue never overwrites its head.
    if (st_acc) wq_head_d = wq_inc(wq_head_q);
    if (wb_en_in && (wq_cnt_d < WQ_CW'(WQ_DEPTH))) begin
      wq_addr_d[wq_tail_d] = wb_addr_in;
      wq_data_d[wq_tail_d] = wb_data_in;
      wq_size_d[wq_tail_d] = wb_size_in;
      wq_tail_d = wq_inc(wq_tail_d);
      wq_cnt_d  = wq_cnt_d + WQ_CW'(1);
    end
    if (wr_en_in && (wq_cnt_d < WQ_CW'(WQ_DEPTH))) begin
      wq_addr_d[wq_tail_d] = wr_addr_in;
      wq_data_d[wq_tail_d] = wr_data_in;
      wq_size_d[wq_tail_d] = wr_size_in;
      wq_tail_d = wq_inc(wq_tail_d);
      wq_cnt_d  = wq_cnt_d + WQ_CW'(1);
    end
    if (st_acc) wq_cnt_d = wq_cnt_d - WQ_CW'(1);

    if (ld_acc) begin
      ms_st_d[load_idx]  = ST_WAIT_DATA;
      ms_tag_d[load_idx] = mem2proc_response;
      iq_head_d          = iq_inc(iq_head_q);
    end
    if (rd_en_in) begin
      if (hit_any) begin
        ms_mask_d[hit_idx] = ms_mask_q[hit_idx] | rd_gnt_in;
      end else if (free_any) begin
        ms_st_d[free_idx]   = ST_WAIT_ISSUE;
        ms_blk_d[free_idx]  = rd_addr_in[15:3];
        ms_mask_d[free_idx] = rd_gnt_in;
        iq_d[iq_tail_q]     = free_idx;
        iq_tail_d           = iq_inc(iq_tail_q);
        iq_push             = 1'b1;
      end
    end
    // Fill uses the post-merge mask so a same-cycle merge is granted too.
    if (ret_any) begin
      fill_en_d          = 1'b1;
      fill_idx_d         = ms_blk_q[ret_idx][4:0];
      fill_tag_d         = ms_blk_q[ret_idx][12:5];
      fill_data_d        = mem2proc_data;
      fill_gnt_d         = ms_mask_d[ret_idx];
      ms_st_d[ret_idx]   = ST_FREE;
      ms_mask_d[ret_idx] = '0;
    end
    iq_cnt_d = iq_cnt_q + MC_W'(iq_push) - MC_W'(ld_acc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wq_head_q   <= '0;
      wq_tail_q   <= '0;
      wq_cnt_q    <= '0;
      ms_st_q     <= '{default: ST_FREE};
      ms_mask_q   <= '{default: '0};
      iq_head_q   <= '0;
      iq_tail_q   <= '0;
      iq_cnt_q    <= '0;
      fill_en_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      fill_data_q <= '0;
      fill_gnt_q  <= '0;
    end else begin
      wq_head_q   <= wq_head_d;
      wq_tail_q   <= wq_tail_d;
      wq_cnt_q    <= wq_cnt_d;
      ms_st_q     <= ms_st_d;
      ms_mask_q   <= ms_mask_d;
      iq_head_q   <= iq_head_d;
      iq_tail_q   <= iq_tail_d;
      iq_cnt_q    <= iq_cnt_d;
      fill_en_q   <= fill_en_d;
      fill_idx_q  <= fill_idx_d;
      fill_tag_q  <= fill_tag_d;
      fill_data_q <= fill_data_d;
      fill_gnt_q  <= fill_gnt_d;
    end
  end

  // Payload storage is only ever read under a valid count/state, so it needs no reset.
  always_ff @(posedge clock) begin
    wq_addr_q <= wq_addr_d;
    wq_data_q <= wq_data_d;
    wq_size_q <= wq_size_d;
    ms_blk_q  <= ms_blk_d;
    ms_tag_q  <= ms_tag_d;
    iq_q      <= iq_d;
  end

  assign fill_en   = fill_en_q;
  assign fill_idx  = fill_idx_q;
  assign fill_tag  = fill_tag_q;
  assign fill_data = fill_data_q;
  assign fill_gnt  = fill_gnt_q;
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of the write queue and outstanding misses.
module tb_dcache_mem_ctrl;
  localparam int LSQSZ = 8, WQ_DEPTH = 4, MSHR_NUM = 4;

  logic clock = 1'b0, reset;
  logic wb_en_in, wr_en_in, rd_en_in;
  logic [15:0] wb_addr_in, wr_addr_in, rd_addr_in;
  logic [63:0] wb_data_in, wr_data_in;
  logic [1:0]  wb_size_in, wr_size_in, rd_size_in;
  logic [LSQSZ-1:0] rd_gnt_in;
  logic req_stall;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic fill_en;
  logic [4:0]  fill_idx;
  logic [7:0]  fill_tag;
  logic [63:0] fill_data;
  logic [LSQSZ-1:0] fill_gnt;

  always #5 clock = ~clock;

  dcache_mem_ctrl #(.LSQSZ(LSQSZ), .WQ_DEPTH(WQ_DEPTH), .MSHR_NUM(MSHR_NUM)) dut (
    .clock(clock), .reset(reset),
    .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in), .wb_size_in(wb_size_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in), .wr_size_in(wr_size_in),
    .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rd_size_in(rd_size_in), .rd_gnt_in(rd_gnt_in),
    .req_stall(req_stall), .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data), .fill_gnt(fill_gnt)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: pending stores in order, and outstanding misses in allocation order.
  typedef struct { logic [15:0] a; logic [63:0] d; logic [1:0] s; } wq_t;
  typedef struct { int id; logic [12:0] blk; logic [7:0] mask; bit issued; logic [3:0] tag; } miss_t;
  wq_t   wq[$];
  miss_t ms[$];
  int    next_id = 0;
  logic        ef_en;
  logic [4:0]  ef_idx;
  logic [7:0]  ef_tag;
  logic [63:0] ef_data;
  logic [7:0]  ef_gnt;
  logic [12:0] pool [6];

  function automatic void model_cmd(output logic [1:0] c, output logic [15:0] a,
                                    output logic [63:0] d, output logic [1:0] s, output int lid);
    c = 2'd0; a = '0; d = '0; s = '0; lid = -1;
    if (wq.size() > 0) begin
      c = 2'd2; a = wq[0].a; d = wq[0].d; s = wq[0].s;
    end else begin
      foreach (ms[k]) if (!ms[k].issued && lid < 0) begin
        c = 2'd1; a = {ms[k].blk, 3'b000}; s = 2'd3; lid = ms[k].id;
      end
    end
  endfunction

  function automatic bit model_stall();
    return ((WQ_DEPTH - wq.size()) < 2) || (ms.size() == MSHR_NUM);
  endfunction

  function automatic bit tag_busy(input logic [3:0] t);
    foreach (ms[k]) if (ms[k].issued && ms[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] free_tag();
    logic [3:0] t;
    do t = 4'($urandom_range(1, 15)); while (tag_busy(t));
    return t;
  endfunction

  task automatic idle();
    reset = 1'b0;
    wb_en_in = 1'b0; wb_addr_in = '0; wb_data_in = '0; wb_size_in = '0;
    wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0; wr_size_in = '0;
    rd_en_in = 1'b0; rd_addr_in = '0; rd_size_in = '0; rd_gnt_in = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  // Check outputs against the model, advance the model with the driven inputs, clock once.
  task automatic tick();
    logic [1:0] ec, es;
    logic [15:0] ea;
    logic [63:0] ed;
    int lid, room, k;
    model_cmd(ec, ea, ed, es, lid);
    check_eq("cmd", proc2mem_command, ec);
    if (ec != 2'd0) begin
      check_eq("addr", proc2mem_addr, ea);
      check_eq("data", proc2mem_data, ed);
      check_eq("size", proc2mem_size, es);
    end
    check_eq("stall", req_stall, model_stall());
    check_eq("fill_en", fill_en, ef_en);
    check_eq("fill_idx", fill_idx, ef_idx);
    check_eq("fill_tag", fill_tag, ef_tag);
    check_eq("fill_data", fill_data, ef_data);
    check_eq("fill_gnt", fill_gnt, ef_gnt);

    ef_en = 1'b0; ef_idx = '0; ef_tag = '0; ef_data = '0; ef_gnt = '0;
    if (reset) begin
      wq.delete();
      ms.delete();
    end else begin
      room = WQ_DEPTH - wq.size();
      if (ec == 2'd2 && mem2proc_response != 4'd0) void'(wq.pop_front());
      if (wb_en_in && room > 0) begin
        wq.push_back('{a: wb_addr_in, d: wb_data_in, s: wb_size_in});
        room--;
      end
      if (wr_en_in && room > 0) wq.push_back('{a: wr_addr_in, d: wr_data_in, s: wr_size_in});
      if (rd_en_in) begin
        k = -1;
        foreach (ms[j]) if (k < 0 && ms[j].blk == rd_addr_in[15:3]) k = j;
        if (k >= 0) ms[k].mask = ms[k].mask | rd_gnt_in;
        else if (ms.size() < MSHR_NUM) begin
          ms.push_back('{id: next_id, blk: rd_addr_in[15:3], mask: rd_gnt_in, issued: 1'b0, tag: 4'd0});
          next_id++;
        end
      end
      if (mem2proc_tag != 4'd0) begin
        k = -1;
        foreach (ms[j]) if (k < 0 && ms[j].issued && ms[j].tag == mem2proc_tag) k = j;
        if (k >= 0) begin
          ef_en = 1'b1; ef_idx = ms[k].blk[4:0]; ef_tag = ms[k].blk[12:5];
          ef_data = mem2proc_data; ef_gnt = ms[k].mask;
          ms.delete(k);
        end
      end
      if (ec == 2'd1 && mem2proc_response != 4'd0)
        foreach (ms[j]) if (ms[j].id == lid) begin
          ms[j].issued = 1'b1;
          ms[j].tag = mem2proc_response;
        end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rand_cycle(input bit allow_new);
    logic [1:0] ec, es;
    logic [15:0] ea;
    logic [63:0] ed;
    int lid;
    logic [3:0] busy[$];
    idle();
    if (allow_new && !model_stall()) begin
      wb_en_in = ($urandom_range(0, 3) == 0);
      wb_addr_in = 16'($urandom); wb_data_in = {$urandom, $urandom}; wb_size_in = 2'($urandom);
      wr_en_in = ($urandom_range(0, 3) == 0);
      wr_addr_in = 16'($urandom); wr_data_in = {$urandom, $urandom}; wr_size_in = 2'($urandom);
      rd_en_in = ($urandom_range(0, 2) == 0);
      rd_addr_in = {pool[$urandom_range(0, 5)], 3'($urandom)};
      rd_size_in = 2'($urandom);
      rd_gnt_in = 8'($urandom);
    end
    model_cmd(ec, ea, ed, es, lid);
    if (ec != 2'd0 && $urandom_range(0, 9) >= 3) mem2proc_response = free_tag();
    foreach (ms[k]) if (ms[k].issued) busy.push_back(ms[k].tag);
    if (busy.size() > 0 && $urandom_range(0, 2) == 0) begin
      mem2proc_tag = busy[$urandom_range(0, busy.size() - 1)];
      mem2proc_data = {$urandom, $urandom};
    end else if ($urandom_range(0, 24) == 0) begin
      mem2proc_tag = free_tag();
      mem2proc_data = {$urandom, $urandom};
    end
    if (allow_new && $urandom_range(0, 299) == 0) reset = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (wq.size() > 0 || ms.size() > 0); i++) rand_cycle(1'b0);
    idle();
    tick();
  endtask

  initial begin
    foreach (pool[i]) pool[i] = 13'($urandom);
    ef_en = 1'b0; ef_idx = '0; ef_tag = '0; ef_data = '0; ef_gnt = '0;
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_cmd", proc2mem_command, 2'd0);
    check_eq("rst_addr", proc2mem_addr, 16'h0);
    check_eq("rst_data", proc2mem_data, 64'h0);
    check_eq("rst_size", proc2mem_size, 2'd0);
    check_eq("rst_stall", req_stall, 1'b0);
    check_eq("rst_fill_en", fill_en, 1'b0);
    check_eq("rst_fill_gnt", fill_gnt, 8'h0);
    idle();

    // Single miss
    rd_en_in = 1'b1; rd_addr_in = 16'h1234; rd_gnt_in = 8'h04; tick();
    check_eq("s1_cmd", proc2mem_command, 2'd1);
    check_eq("s1_addr", proc2mem_addr, 16'h1230);
    check_eq("s1_size", proc2mem_size, 2'd3);
    idle(); mem2proc_response = 4'd3; tick();
    idle(); mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD; tick();
    check_eq("s1_fill_en", fill_en, 1'b1);
    check_eq("s1_fill_idx", fill_idx, 5'h06);
    check_eq("s1_fill_tag", fill_tag, 8'h12);
    check_eq("s1_fill_data", fill_data, 64'hDEAD);
    check_eq("s1_fill_gnt", fill_gnt, 8'h04);
    idle(); tick();
    check_eq("s1_pulse", fill_en, 1'b0);

    // Merge: second miss to same block folds into the outstanding entry
    rd_en_in = 1'b1; rd_addr_in = 16'h1230; rd_gnt_in = 8'h01; tick();
    idle(); rd_en_in = 1'b1; rd_addr_in = 16'h1236; rd_gnt_in = 8'h10; mem2proc_response = 4'd3; tick();
    check_eq("mg_one_load", proc2mem_command, 2'd0);
    idle(); mem2proc_tag = 4'd3; mem2proc_data = 64'h55; tick();
    check_eq("mg_fill_gnt", fill_gnt, 8'h11);
    idle(); tick();

    // Ordering: both stores drain before the load
    wb_en_in = 1'b1; wb_addr_in = 16'h0100; wb_data_in = 64'h1; wb_size_in = 2'd3;
    wr_en_in = 1'b1; wr_addr_in = 16'h0208; wr_data_in = 64'h2; wr_size_in = 2'd2; tick();
    check_eq("ord_0", proc2mem_addr, 16'h0100);
    idle(); rd_en_in = 1'b1; rd_addr_in = 16'h0200; rd_gnt_in = 8'h02; mem2proc_response = 4'd5; tick();
    check_eq("ord_1", proc2mem_addr, 16'h0208);
    idle(); mem2proc_response = 4'd5; tick();
    check_eq("ord_2_cmd", proc2mem_command, 2'd1);
    check_eq("ord_2", proc2mem_addr, 16'h0200);
    idle(); mem2proc_response = 4'd6; tick();
    idle(); mem2proc_tag = 4'd6; tick();
    idle(); tick();

    // Backpressure on a load and on a store
    rd_en_in = 1'b1; rd_addr_in = 16'h4000; rd_gnt_in = 8'h80; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check_eq("bp_ld_hold", proc2mem_addr, 16'h4000);
    end
    idle(); mem2proc_response = 4'd7; tick();
    check_eq("bp_ld_done", proc2mem_command, 2'd0);
    idle(); mem2proc_tag = 4'd7; tick();
    idle(); wb_en_in = 1'b1; wb_addr_in = 16'h0300; wb_data_in = 64'hABCD; wb_size_in = 2'd1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check_eq("bp_st_hold", proc2mem_command, 2'd2);
    end
    idle(); mem2proc_response = 4'd1; tick();
    check_eq("bp_st_done", proc2mem_command, 2'd0);

    // Full MSHRs, then write-queue threshold
    for (int i = 0; i < 4; i++) begin
      idle(); rd_en_in = 1'b1; rd_addr_in = 16'h2000 + 16'(i * 8); rd_gnt_in = 8'(1 << i); tick();
    end
    check_eq("full_stall", req_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(); mem2proc_response = 4'(i + 1); tick();
    end
    idle(); mem2proc_tag = 4'd1; tick();
    check_eq("full_unstall", req_stall, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      idle(); mem2proc_tag = 4'(i); tick();
    end
    idle(); wb_en_in = 1'b1; wb_addr_in = 16'h0400; wr_en_in = 1'b1; wr_addr_in = 16'h0408; tick();
    check_eq("wq2_stall", req_stall, 1'b0);
    idle(); wb_en_in = 1'b1; wb_addr_in = 16'h0500; tick();
    check_eq("wq3_stall", req_stall, 1'b1);
    drain();

    // Reset with two loads in flight; late returns must be ignored
    idle(); rd_en_in = 1'b1; rd_addr_in = 16'h6000; rd_gnt_in = 8'h01; tick();
    idle(); rd_en_in = 1'b1; rd_addr_in = 16'h6008; rd_gnt_in = 8'h02; mem2proc_response = 4'd9; tick();
    idle(); mem2proc_response = 4'd10; tick();
    idle(); reset = 1'b1; tick();
    idle(); mem2proc_tag = 4'd9; mem2proc_data = 64'h99; tick();
    check_eq("rst_late_fill", fill_en, 1'b0);
    check_eq("rst_late_cmd", proc2mem_command, 2'd0);
    idle(); mem2proc_tag = 4'd10; tick();
    check_eq("rst_late_fill2", fill_en, 1'b0);

    for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
